// File: rtl/rr_enc8to3_if.sv
// Request/grant bundle between the requesters, the encoder and the control FSM.
interface rr_enc8to3_if;
    logic [7:0] req;
    logic       en;
    logic       ack;
    logic [2:0] w;
    logic [7:0] grant;
    logic       valid;

    modport master (output req, output en, output ack,
                    input  w,   input  grant, input valid);
    modport slave  (input  req, input  en, input  ack,
                    output w,   output grant, output valid);
endinterface

// File: rtl/rr_enc8to3.sv
// Registered round-robin 8-to-3 encoder: picks one requester, returns its index
// plus a one-hot grant, and holds the grant until acknowledged.
module rr_enc8to3 #(
    parameter bit ROTATE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    rr_enc8to3_if.slave   bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] w_q, w_nx;
    logic [7:0] grant_q, grant_nx;
    logic       valid_q, valid_nx;
    logic [2:0] w_inc;

    // First set bit scanning p, p+1, ... p+7 modulo 8.
    function automatic logic [2:0] sel(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign w_inc = w_q + 3'd1;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        w_nx     = w_q;
        grant_nx = grant_q;
        valid_nx = valid_q;
        unique case (state)
            IDLE: begin
                if (bus.en && (bus.req != '0)) begin
                    w_nx     = sel(bus.req, ROTATE ? ptr : 3'd0);
                    grant_nx = '0;
                    grant_nx[w_nx] = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.ack) begin
                    if (ROTATE) ptr_nx = w_inc;
                    if (bus.en && (bus.req != '0)) begin
                        w_nx     = sel(bus.req, ROTATE ? w_inc : 3'd0);
                        grant_nx = '0;
                        grant_nx[w_nx] = 1'b1;
                        valid_nx = 1'b1;
                    end else begin
                        grant_nx = '0;
                        valid_nx = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            w_q     <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            w_q     <= w_nx;
            grant_q <= grant_nx;
            valid_q <= valid_nx;
        end
    end

    assign bus.w     = w_q;
    assign bus.grant = grant_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_rr_enc8to3.sv
// Directed bench for rr_enc8to3: round-robin instance plus a fixed-priority instance.
module tb_rr_enc8to3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    rr_enc8to3_if rr_bus ();
    rr_enc8to3_if fx_bus ();

    rr_enc8to3 #(.ROTATE(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(rr_bus.slave));
    rr_enc8to3 #(.ROTATE(1'b0)) dut_fx (.clk(clk), .rst(rst), .bus(fx_bus.slave));

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rr(input logic [7:0] r, input logic e, input logic a);
        rr_bus.req = r;
        rr_bus.en  = e;
        rr_bus.ack = a;
    endtask

    task automatic expect_rr(input string tag, input logic [2:0] w, input logic v);
        logic [7:0] g;
        g = '0;
        if (v) g[w] = 1'b1;
        check({tag, "_w"}, 8'(rr_bus.w), 8'(w));
        check({tag, "_grant"}, rr_bus.grant, g);
        check({tag, "_valid"}, 8'(rr_bus.valid), 8'(v));
    endtask

    initial begin
        drive_rr(8'h00, 1'b0, 1'b0);
        fx_bus.req = '0;
        fx_bus.en  = 1'b0;
        fx_bus.ack = 1'b0;

        rst = 1'b1;
        step();
        expect_rr("reset", 3'd0, 1'b0);
        check("fx_reset_valid", 8'(fx_bus.valid), 8'd0);
        rst = 1'b0;

        // Basic grant
        drive_rr(8'b0010_0100, 1'b1, 1'b0);
        step();
        expect_rr("basic", 3'd2, 1'b1);

        // Round-robin advance
        drive_rr(8'b0010_0100, 1'b1, 1'b1);
        step();
        expect_rr("rr_adv1", 3'd5, 1'b1);
        drive_rr(8'b0010_0100, 1'b1, 1'b0);
        step();
        expect_rr("rr_hold", 3'd5, 1'b1);
        drive_rr(8'b0010_0100, 1'b1, 1'b1);
        step();
        expect_rr("rr_adv2", 3'd2, 1'b1);

        // Wrap-around
        drive_rr(8'b1000_0000, 1'b1, 1'b1);
        step();
        expect_rr("wrap_w7", 3'd7, 1'b1);
        drive_rr(8'b1000_0001, 1'b1, 1'b1);
        step();
        expect_rr("wrap_w0", 3'd0, 1'b1);
        step();
        expect_rr("wrap_back7", 3'd7, 1'b1);

        // Hold while BUSY regardless of Req/En
        drive_rr(8'b0000_1000, 1'b1, 1'b1);
        step();
        expect_rr("hold_setup", 3'd3, 1'b1);
        drive_rr(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_rr("hold", 3'd3, 1'b1);
        end
        drive_rr(8'h00, 1'b0, 1'b1);
        step();
        expect_rr("release", 3'd3, 1'b0);

        // En=0 blocks grants in IDLE; Ack ignored in IDLE
        drive_rr(8'hFF, 1'b0, 1'b1);
        step();
        expect_rr("en_off1", 3'd3, 1'b0);
        step();
        expect_rr("en_off2", 3'd3, 1'b0);

        // Pointer retained across IDLE (Ptr=4)
        drive_rr(8'hFF, 1'b1, 1'b0);
        step();
        expect_rr("ptr_kept", 3'd4, 1'b1);

        // Reset mid-BUSY overrides Ack
        drive_rr(8'b0100_0000, 1'b1, 1'b1);
        step();
        expect_rr("pre_rst", 3'd6, 1'b1);
        rst = 1'b1;
        drive_rr(8'b0100_0000, 1'b1, 1'b1);
        step();
        expect_rr("mid_rst", 3'd0, 1'b0);
        rst = 1'b0;
        drive_rr(8'b0100_0001, 1'b1, 1'b0);
        step();
        expect_rr("post_rst", 3'd0, 1'b1);
        drive_rr(8'b0100_0001, 1'b1, 1'b1);
        step();
        expect_rr("post_rst_adv", 3'd6, 1'b1);
        drive_rr(8'h00, 1'b0, 1'b1);
        step();
        expect_rr("rr_idle", 3'd6, 1'b0);

        // Fixed priority: bit 0 always wins
        fx_bus.req = 8'b1000_0001;
        fx_bus.en  = 1'b1;
        fx_bus.ack = 1'b0;
        step();
        check("fx_first_w", 8'(fx_bus.w), 8'd0);
        check("fx_first_grant", fx_bus.grant, 8'h01);
        fx_bus.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fx_w", 8'(fx_bus.w), 8'd0);
            check("fx_valid", 8'(fx_bus.valid), 8'd1);
        end
        fx_bus.req = 8'b1000_0000;
        step();
        check("fx_low_w", 8'(fx_bus.w), 8'd7);
        check("fx_low_grant", fx_bus.grant, 8'h80);
        fx_bus.req = 8'h00;
        step();
        check("fx_idle_grant", fx_bus.grant, 8'h00);
        check("fx_idle_valid", 8'(fx_bus.valid), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_enc8to3.md
# rr_enc8to3

Registered round-robin 8-to-3 encoder, the inverse of the processor's 3-to-8 one-hot decoder. It takes eight request lines (register-file or peripheral requesters), picks one, and returns its 3-bit binary index plus a one-hot grant. The grant is held stable until the consumer acknowledges it. It sits between the requesters and the control FSM, which consumes the index and feeds it back through the decoder.

## Interface
- ROTATE, default 1: 1 gives round-robin priority starting at pointer Ptr; 0 gives fixed priority, where bit 0 is highest and bit 7 is lowest.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  8  request vector; bit i high means requester i wants service.
- En  in  1  enables new grants; has no effect on a grant already issued.
- Ack  in  1  consumer accepts the current grant; sampled only while Valid=1.
- W  out  3  binary index of the granted requester.
- Grant  out  8  one-hot of W while Valid=1; 8'b0 otherwise.
- Valid  out  1  W and Grant hold a live grant.

## Operation
- State: FSM {IDLE, BUSY} and a 3-bit pointer Ptr. All outputs are registered.
- Selection function sel(Req, p): the first set bit found scanning p, p+1, …, p+7 mod 8. With ROTATE=0, p is forced to 0.
- IDLE:
  - If En=1 and Req≠0: W←sel(Req,Ptr), Grant←1<<W, Valid←1, go to BUSY.
  - Otherwise stay in IDLE with outputs unchanged (Valid=0, Grant=0).
- BUSY, Ack=0:
  - W, Grant and Valid are held.
  - Req and En changes are ignored, including the granted bit dropping.
- BUSY, Ack=1:
  - Ptr←W+1 mod 8; 7 wraps to 0. Ptr is unchanged when ROTATE=0.
  - If En=1 and Req≠0 in the same cycle: immediate re-grant with W←sel(Req, W+1) (ROTATE=1) or sel(Req,0) (ROTATE=0). Stay in BUSY with Valid=1.
  - Else: Valid←0, Grant←0, go to IDLE. W keeps its last value.
  - Req is sampled as-is in the Ack cycle; the just-acknowledged bit may be set and competes normally.
- Ack while in IDLE is ignored.
- Grant is one-hot or zero at all times; Grant=0 exactly when Valid=0.

## Timing
- Reset (at any clock edge, including mid-BUSY): state=IDLE, Ptr=0, W=3'b000, Grant=8'b0, Valid=0, all on the edge where Reset=1. Reset overrides Ack and En.
- Latency: Req/En sampled at edge n gives Valid, W and Grant at edge n (visible during cycle n+1).
- Ack sampled at edge n gives the next grant or Valid=0 at edge n, so throughput is one grant per cycle when Ack is held high.
- A grant issued at edge n cannot be acknowledged before edge n+1.
- No combinational path from inputs to outputs.

## Test plan
- Basic grant, 1-cycle latency:
  - Stimulus: Reset, then Req=8'b0010_0100, En=1.
  - Response: one edge later W=2, Grant=8'b0000_0100, Valid=1.
- Round-robin advance:
  - Stimulus: continuing from the basic grant, hold Req and pulse Ack=1 for one cycle.
  - Response: next W=5, Grant=8'b0010_0000, Valid=1.
  - Stimulus: Ack again with Req unchanged.
  - Response: W=2.
- Wrap-around:
  - Stimulus: grant W=7 and Ack it (Ptr→0), then present Req=8'b1000_0001.
  - Response: W=0.
  - Stimulus: Ack.
  - Response: W=7.
- Hold and En:
  - Stimulus: in BUSY with W=3, set Req=0, En=0, Ack=0 for 5 cycles.
  - Response: W=3, Grant=8'b0000_1000, Valid=1 throughout.
  - Stimulus: Ack with Req=0.
  - Response: Valid=0, Grant=0.
  - Stimulus: En=0 with Req≠0 in IDLE.
  - Response: Valid stays 0.
- Fixed priority (ROTATE=0):
  - Stimulus: Req=8'b1000_0001 held, Ack held high for 4 cycles.
  - Response: W=0 every cycle; bit 7 is never granted.
- Reset mid-operation:
  - Stimulus: in BUSY with W=6, assert Reset together with Ack=1.
  - Response: next edge gives Valid=0, Grant=0, W=0, Ptr=0.
  - Stimulus: Req=8'b0100_0001 after Reset is released.
  - Response: W=0.
